frame_update_scheduler: RTL and testbench

FRAME_UPDATE_SCHEDULER -- requirements
Module: frame_update_scheduler

---
 rtl/frame_update_scheduler_pkg.sv | 22 ++
 rtl/frame_update_scheduler_btn_debounce.sv | 43 ++++
 rtl/frame_update_scheduler.sv | 150 +++++++++++++++
 tb/tb_frame_update_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_update_scheduler_pkg.sv
`default_nettype none
// Shared constants, client indices and FSM encoding for the frame update scheduler.
package frame_update_scheduler_pkg;

  localparam int DEF_NUM_CLIENTS     = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_ACK_TIMEOUT     = 1024;

  localparam int CLIENT_ME     = 0;
  localparam int CLIENT_BOARD  = 1;
  localparam int CLIENT_SEATS  = 2;
  localparam int CLIENT_PODIUM = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_update_scheduler_btn_debounce.sv
`default_nettype none
// One button bit: 2-flop synchronizer followed by a consecutive-mismatch debounce counter.
module btn_debounce
  import frame_update_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic ClkPort,
  input  logic Reset,
  input  logic raw,
  output logic level
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any cycle agreeing with the accepted level restarts the count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_update_scheduler.sv
`default_nettype none
// Per-frame sequencer: on each vSync fall, latches debounced buttons and
// issues one-hot update requests to enabled clients in index order.
module frame_update_scheduler
  import frame_update_scheduler_pkg::*;
#(
  parameter int NUM_CLIENTS     = DEF_NUM_CLIENTS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ACK_TIMEOUT     = DEF_ACK_TIMEOUT
) (
  input  logic                   ClkPort,
  input  logic                   Reset,
  input  logic                   vSync,
  input  logic [3:0]             btn,
  input  logic [NUM_CLIENTS-1:0] en,
  input  logic [NUM_CLIENTS-1:0] upd_ack,
  input  logic                   clr,
  output logic [NUM_CLIENTS-1:0] upd_req,
  output logic [3:0]             dir,
  output logic [15:0]            frame_cnt,
  output logic                   busy,
  output logic                   overrun,
  output logic [NUM_CLIENTS-1:0] timeout
);

  localparam int            IW       = $clog2(NUM_CLIENTS + 1);
  localparam int            TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);

  // Flops reset high so that releasing reset with vSync idle is not an edge.
  logic vs_sync1;
  logic vs_sync2;
  logic vs_prev;
  logic frame_start;

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      vs_sync1 <= 1'b1;
      vs_sync2 <= 1'b1;
      vs_prev  <= 1'b1;
    end else begin
      vs_sync1 <= vSync;
      vs_sync2 <= vs_sync1;
      vs_prev  <= vs_sync2;
    end
  end

  assign frame_start = vs_prev & ~vs_sync2;

  logic [3:0] btn_level;

  for (genvar b = 0; b < 4; b++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .ClkPort(ClkPort),
      .Reset  (Reset),
      .raw    (btn[b]),
      .level  (btn_level[b])
    );
  end

  sched_state_t          state;
  logic [IW-1:0]         idx;
  logic [TW-1:0]         tmr;
  logic [IW-1:0]         sel;
  logic                  sel_valid;
  logic                  ack_hit;
  logic                  ack_expired;
  logic [NUM_CLIENTS-1:0] timeout_set;
  logic                  overrun_set;

  // Lowest enabled client at or above the current index.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (en[i] && (IW'(i) >= idx)) begin
        sel       = IW'(i);
        sel_valid = 1'b1;
      end
    end
  end

  assign ack_hit     = |(upd_ack & upd_req);
  assign ack_expired = (state == ST_WAIT_ACK) && !ack_hit && (tmr == TMR_LAST);
  assign timeout_set = ack_expired ? upd_req : '0;
  assign overrun_set = frame_start && (state != ST_IDLE);

  // Set events are OR-ed in after the clear so a same-cycle set survives.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      overrun <= 1'b0;
      timeout <= '0;
    end else begin
      overrun <= (overrun & ~clr) | overrun_set;
      timeout <= (clr ? '0 : timeout) | timeout_set;
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      tmr       <= '0;
      upd_req   <= '0;
      dir       <= 4'b0000;
      frame_cnt <= 16'h0000;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            dir   <= btn_level;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sel_valid) begin
            idx     <= sel;
            tmr     <= '0;
            upd_req <= NUM_CLIENTS'(1) << sel;
            state   <= ST_WAIT_ACK;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_hit || ack_expired) begin
            upd_req <= '0;
            idx     <= idx + IW'(1);
            state   <= ST_ISSUE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        ST_DONE: begin
          frame_cnt <= frame_cnt + 16'd1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_update_scheduler.sv
`default_nettype none
// Directed, table-driven bench for frame_update_scheduler (DEBOUNCE_CYCLES=4, ACK_TIMEOUT=8).
module tb_frame_update_scheduler;

  localparam int N = 4;

  logic         ClkPort = 1'b0;
  logic         Reset   = 1'b1;
  logic         vSync   = 1'b1;
  logic [3:0]   btn     = 4'b0000;
  logic [N-1:0] en      = '0;
  logic [N-1:0] upd_ack = '0;
  logic         clr     = 1'b0;
  logic [N-1:0] upd_req;
  logic [3:0]   dir;
  logic [15:0]  frame_cnt;
  logic         busy;
  logic         overrun;
  logic [N-1:0] timeout;

  int tests = 0;
  int fails = 0;

  frame_update_scheduler #(
    .NUM_CLIENTS    (N),
    .DEBOUNCE_CYCLES(4),
    .ACK_TIMEOUT    (8)
  ) dut (
    .ClkPort  (ClkPort),
    .Reset    (Reset),
    .vSync    (vSync),
    .btn      (btn),
    .en       (en),
    .upd_ack  (upd_ack),
    .clr      (clr),
    .upd_req  (upd_req),
    .dir      (dir),
    .frame_cnt(frame_cnt),
    .busy     (busy),
    .overrun  (overrun),
    .timeout  (timeout)
  );

  always #5 ClkPort = ~ClkPort;

  typedef struct {
    logic [3:0] en;
    logic [3:0] noack;
    int         ack_age;
    bit         stray;
    bit         clr_on_to;
    int         ov_client;
    bit         drop_en;
    logic [3:0] exp_mask;
    logic [3:0] exp_to;
    bit         exp_ov;
  } vec_t;

  vec_t vecs[9];

  logic [3:0] got_mask;
  bit         got_order;
  bit         got_dur;
  bit         got_onehot;
  bit         got_fin;
  int         got_first;
  logic [15:0] exp_cnt;
  bit         found;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] en_v, input logic [3:0] noack_v, input int age_v,
                              input bit stray_v, input bit clr_v, input int ov_v, input bit drop_v,
                              input logic [3:0] mask_v, input logic [3:0] to_v, input bit ov_exp);
    vec_t v;
    v.en = en_v; v.noack = noack_v; v.ack_age = age_v; v.stray = stray_v; v.clr_on_to = clr_v;
    v.ov_client = ov_v; v.drop_en = drop_v; v.exp_mask = mask_v; v.exp_to = to_v; v.exp_ov = ov_exp;
    return v;
  endfunction

  // Drops vSync, then acts as every client: acks after ack_age cycles of request unless noack.
  task automatic run_frame(input vec_t v);
    logic [3:0] prev;
    int         age;
    int         cur;
    int         last;
    int         exp_dur;
    bit         seen_busy;
    bit         ov_fired;
    got_mask = '0; got_order = 1; got_dur = 1; got_onehot = 1; got_fin = 0; got_first = -1;
    prev = '0; age = 0; cur = 0; last = -1; seen_busy = 0; ov_fired = 0;
    en = v.en;
    @(negedge ClkPort);
    vSync = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      @(negedge ClkPort);
      if ($countones(upd_req) > 1) got_onehot = 0;
      if (busy) seen_busy = 1;
      if (busy && !ov_fired) vSync = 1'b1;
      if (upd_req != 0 && prev == 0) begin
        for (int k = 0; k < N; k++) if (upd_req[k]) cur = k;
        got_mask |= upd_req;
        if (cur <= last) got_order = 0;
        last = cur;
        if (got_first < 0) got_first = e;
        age = 0;
        if (v.drop_en) en = en & ~upd_req;
        if (cur == v.ov_client && !ov_fired) begin
          vSync = 1'b0;
          ov_fired = 1;
        end
      end else if (upd_req != 0) begin
        age++;
      end
      if (upd_req == 0 && prev != 0) begin
        exp_dur = v.noack[cur] ? 8 : v.ack_age + 1;
        if (age + 1 != exp_dur) got_dur = 0;
      end
      upd_ack = '0;
      if (upd_req != 0 && age == v.ack_age && !v.noack[cur]) upd_ack = upd_req;
      if (v.stray) upd_ack = upd_ack | ~upd_req;
      clr = v.clr_on_to && (upd_req != 0) && v.noack[cur] && (age == 7);
      prev = upd_req;
      if (seen_busy && !busy) begin
        got_fin = 1;
        break;
      end
    end
    upd_ack = '0;
    clr     = 1'b0;
    vSync   = 1'b1;
    repeat (4) @(negedge ClkPort);
  endtask

  initial begin
    vecs[0] = mk(4'b1111, 4'b0000, 2, 0, 0, -1, 0, 4'b1111, 4'b0000, 0);
    vecs[1] = mk(4'b0101, 4'b0000, 2, 0, 0, -1, 0, 4'b0101, 4'b0000, 0);
    vecs[2] = mk(4'b0000, 4'b0000, 2, 0, 0, -1, 0, 4'b0000, 4'b0000, 0);
    vecs[3] = mk(4'b1111, 4'b0010, 2, 0, 0, -1, 0, 4'b1111, 4'b0010, 0);
    vecs[4] = mk(4'b1010, 4'b0000, 0, 0, 0, -1, 0, 4'b1010, 4'b0000, 0);
    vecs[5] = mk(4'b1001, 4'b1000, 2, 1, 0, -1, 0, 4'b1001, 4'b1000, 0);
    vecs[6] = mk(4'b0010, 4'b0010, 2, 0, 1, -1, 0, 4'b0010, 4'b0010, 0);
    vecs[7] = mk(4'b1111, 4'b0000, 2, 0, 0,  2, 0, 4'b1111, 4'b0000, 1);
    vecs[8] = mk(4'b1111, 4'b0000, 2, 0, 0, -1, 1, 4'b1111, 4'b0000, 0);

    repeat (3) @(negedge ClkPort);
    check("rst_upd_req", upd_req, 0);
    check("rst_dir", dir, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);
    Reset = 1'b0;
    repeat (4) @(negedge ClkPort);
    check("idle_after_rst", busy, 0);
    exp_cnt = 16'h0000;

    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i]);
      exp_cnt = exp_cnt + 16'd1;
      check($sformatf("v%0d_finished", i), got_fin, 1);
      check($sformatf("v%0d_req_mask", i), got_mask, vecs[i].exp_mask);
      check($sformatf("v%0d_order", i), got_order, 1);
      check($sformatf("v%0d_first_req_edge", i), got_first, (vecs[i].exp_mask != 0) ? 4 : -1);
      check($sformatf("v%0d_req_duration", i), got_dur, 1);
      check($sformatf("v%0d_onehot", i), got_onehot, 1);
      check($sformatf("v%0d_timeout", i), timeout, vecs[i].exp_to);
      check($sformatf("v%0d_overrun", i), overrun, vecs[i].exp_ov);
      check($sformatf("v%0d_frame_cnt", i), frame_cnt, exp_cnt);
      check($sformatf("v%0d_busy_end", i), busy, 0);
      clr = 1'b1;
      @(negedge ClkPort);
      clr = 1'b0;
      check($sformatf("v%0d_clr_timeout", i), timeout, 0);
      check($sformatf("v%0d_clr_overrun", i), overrun, 0);
    end

    // Bounce shorter than the debounce window must not reach dir.
    btn = 4'b1000;
    repeat (3) @(negedge ClkPort);
    btn = 4'b0000;
    repeat (8) @(negedge ClkPort);
    run_frame(vecs[2]);
    exp_cnt = exp_cnt + 16'd1;
    check("dir_bounce_only", dir, 4'b0000);

    btn = 4'b1000;
    repeat (3) @(negedge ClkPort);
    btn = 4'b0000;
    @(negedge ClkPort);
    btn = 4'b1000;
    repeat (10) @(negedge ClkPort);
    run_frame(vecs[2]);
    exp_cnt = exp_cnt + 16'd1;
    check("dir_held_up", dir, 4'b1000);
    btn = 4'b0000;
    repeat (10) @(negedge ClkPort);
    check("dir_holds_between_frames", dir, 4'b1000);
    run_frame(vecs[2]);
    exp_cnt = exp_cnt + 16'd1;
    check("dir_released", dir, 4'b0000);
    check("dbn_frame_cnt", frame_cnt, exp_cnt);

    // Wrap of the frame counter from a preloaded 0xFFFF.
    @(negedge ClkPort);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge ClkPort);
    release dut.frame_cnt;
    run_frame(vecs[2]);
    check("frame_cnt_wrap", frame_cnt, 16'h0000);

    // Reset asserted while a request is pending.
    en = 4'b1111;
    @(negedge ClkPort);
    vSync = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ClkPort);
      if (upd_req != 0) begin
        found = 1;
        break;
      end
    end
    check("rst_mid_req_seen", found, 1);
    run_frame(vecs[2]);
    en = 4'b1111;
    vSync = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ClkPort);
      if (upd_req != 0) begin
        found = 1;
        break;
      end
    end
    check("rst_mid_cnt_nonzero", (frame_cnt != 0), 1);
    @(negedge ClkPort);
    #2 Reset = 1'b1;
    #1;
    check("rst_mid_upd_req", upd_req, 0);
    check("rst_mid_frame_cnt", frame_cnt, 0);
    check("rst_mid_busy", busy, 0);
    vSync = 1'b1;
    @(negedge ClkPort);
    Reset = 1'b0;
    found = 0;
    repeat (12) begin
      @(negedge ClkPort);
      if (busy || upd_req != 0) found = 1;
    end
    check("rst_no_resume", found, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
